interleave_addr_ctrl: RTL and testbench
=======================================

INTERLEAVE_ADDR_CTRL -- requirements
Module: interleave_addr_ctrl

Interface
REQ-001 Parameter ROWS, default 32: interleaver matrix rows.
REQ-002 Parameter COLS, default 64: interleaver matrix columns; ROWS*COLS SHALL be <= 2048.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mode  input  1  0 = encode (write row-major, read column-major); 1 = decode (write column-major, read row-major).
REQ-006 in_valid  input  1  upstream symbol present.
REQ-007 in_ready  output  1  controller accepts symbol this cycle.
REQ-008 wr_en  output  1  RAM write strobe, equal to in_valid && in_ready.
REQ-009 wr_addr  output  12  RAM write address {bank, 11-bit offset}.
REQ-010 rd_en  output  1  RAM read strobe.
REQ-011 rd_addr  output  12  RAM read address {bank, 11-bit offset}.
REQ-012 out_valid  output  1  RAM read data valid to downstream.
REQ-013 out_ready  input  1  downstream accepts data.
REQ-014 blk_done  output  1  one-cycle pulse when final symbol of a block is read.

Function
REQ-015 Two ping-pong banks SHALL be managed with per-bank full flags, a write-bank pointer and a read-bank pointer.
REQ-016 Offset SHALL be row*COLS+col; row-major order increments col innermost; column-major order increments row innermost.
REQ-017 in_ready SHALL be 1 iff the current write bank's full flag is 0.
REQ-018 On each wr_en the write (row,col) counter SHALL advance in the bank's write order; on the ROWS*COLS-th write the bank full flag SHALL set, counters SHALL clear and the write-bank pointer SHALL toggle.
REQ-019 mode SHALL be sampled on the first write of each block and stored per bank; changes mid-block SHALL be ignored until the next block.
REQ-020 rd_en SHALL be 1 iff the read bank is full and (out_valid==0 or out_ready==1).
REQ-021 On each rd_en the read counter SHALL advance in the order opposite to that bank's stored write order.
REQ-022 out_valid SHALL assert the cycle after rd_en (1-cycle RAM latency) and hold while out_ready==0; the RAM holds its output when rd_en==0.
REQ-023 On the last read of a bank, that bank's full flag SHALL clear, the read pointer SHALL toggle, and blk_done SHALL pulse the following cycle with the last out_valid.
REQ-024 Simultaneous completion of a write block and a read block in the same cycle SHALL apply both flag updates without loss.
REQ-025 A bank freed by its last read SHALL be writable from the next cycle (in_ready rises one cycle after the last rd_en).
REQ-026 With both banks full, in_ready SHALL be 0 and no wr_en SHALL occur.
REQ-027 rd_en and wr_en SHALL never target the same bank in the same cycle.

Reset
REQ-028 On rst: full flags 0, both pointers bank 0, all counters 0, stored modes 0, wr_en/rd_en/out_valid/blk_done 0, addresses 0.
REQ-029 rst mid-block SHALL discard partial blocks; in_ready SHALL be 1 the cycle after rst deasserts.

Structure
REQ-030 Package interleave_pkg SHALL hold ADDR_W=12, OFS_W=11, default ROWS/COLS and mode encodings MODE_ENC=0, MODE_DEC=1.
REQ-031 Sub-module interleave_addr_gen (row/col counter, order select, offset compute, wrap flag) SHALL be instantiated once for write and once for read.

Verification (ROWS=4, COLS=8)
REQ-032 Encode, 32 continuous writes, out_ready=1 -> wr_addr 0..31 bank 0; then rd_addr 0,8,16,24,1,9,... bank 0; blk_done with 32nd out_valid.
REQ-033 Decode block -> wr_addr 0,8,16,24,1,...; rd_addr 0,1,2,...,31; data order restored end-to-end with encode block.
REQ-034 out_ready=0 throughout, 64 writes offered -> both banks full, in_ready=0 after 64th write, no rd_en beyond first, out_valid held.
REQ-035 Streaming with last write of bank 1 coinciding with last read of bank 0 -> both flags update, in_ready=1 next cycle, no symbol lost.
REQ-036 rst asserted after 17 writes -> all outputs at reset values; next block writes from bank 0 offset 0.
REQ-037 mode toggled at write 10 of a block -> block completes in original order; new mode applies to the next block.

Source files
------------

// File: rtl/interleave_pkg.sv
// Shared definitions for the block interleaver address controller.
// Holds the RAM address geometry ({bank, offset}), the default matrix
// dimensions and the encode/decode mode encoding.
package interleave_pkg;

    localparam int ADDR_W   = 12;   // {bank bit, OFS_W-bit offset}
    localparam int OFS_W    = 11;   // offset within one bank
    localparam int DEF_ROWS = 32;
    localparam int DEF_COLS = 64;

    // Encode writes row-major and reads column-major; decode does the reverse.
    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

endpackage

// File: rtl/interleave_addr_gen.sv
// Row/column address generator for one side (write or read) of the
// interleaver.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset, returns to (row 0, col 0)
//   adv_i        advance to the next matrix position this cycle
//   col_major_i  1 = row index runs innermost, 0 = column index runs innermost
//   ofs_o        bank offset of the current position, row*COLS+col
//   last_o       current position is the final one of the block; advancing
//                from it wraps back to (0,0)
module interleave_addr_gen
    import interleave_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_i,
    input  logic             col_major_i,
    output logic [OFS_W-1:0] ofs_o,
    output logic             last_o
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          row_wrap;
    logic          col_wrap;

    assign row_wrap = (row_q == ROW_MAX);
    assign col_wrap = (col_q == COL_MAX);

    // Both traversal orders finish on the bottom-right element.
    assign last_o = row_wrap && col_wrap;
    assign ofs_o  = OFS_W'(row_q) * OFS_W'(COLS) + OFS_W'(col_q);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (adv_i) begin
            if (last_o) begin
                row_d = '0;
                col_d = '0;
            end else if (col_major_i) begin
                if (row_wrap) begin
                    row_d = '0;
                    col_d = col_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                if (col_wrap) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/interleave_addr_ctrl.sv
// Ping-pong block interleaver address controller. Manages two RAM banks:
// symbols are written into one bank in the block's write order while the
// other, completed bank is read back in the transposed order.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; discards partial blocks
//   mode       0 = encode, 1 = decode; captured on the first write of a block
//   in_valid   upstream symbol present
//   in_ready   current write bank is not full
//   wr_en      RAM write strobe (in_valid && in_ready)
//   wr_addr    RAM write address {bank, offset}
//   rd_en      RAM read strobe
//   rd_addr    RAM read address {bank, offset}
//   out_valid  RAM read data valid (one cycle after rd_en, held on stall)
//   out_ready  downstream accepts data
//   blk_done   pulses together with the last out_valid of a block
module interleave_addr_ctrl
    import interleave_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              blk_done
);

    logic [1:0]       full_q, full_d;
    logic [1:0]       bank_mode_q, bank_mode_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic             out_valid_q, out_valid_d;
    logic             blk_done_q, blk_done_d;

    logic [OFS_W-1:0] wr_ofs;
    logic [OFS_W-1:0] rd_ofs;
    logic             wr_last;
    logic             rd_last;
    logic             wr_first;
    mode_e            wr_mode;
    mode_e            rd_mode;
    logic             wr_col_major;
    logic             rd_col_major;

    assign in_ready = ~full_q[wr_bank_q];
    assign wr_en    = in_valid & in_ready;
    // A read may issue only into an empty or draining output register.
    assign rd_en    = full_q[rd_bank_q] & (~out_valid_q | out_ready);

    // The write counter sits at offset 0 only before the first write of a
    // block, so that is where the live mode input is taken; afterwards the
    // value stored for the bank steers the order.
    assign wr_first     = (wr_ofs == '0);
    assign wr_mode      = wr_first ? mode_e'(mode) : mode_e'(bank_mode_q[wr_bank_q]);
    assign rd_mode      = mode_e'(bank_mode_q[rd_bank_q]);
    assign wr_col_major = (wr_mode == MODE_DEC);
    assign rd_col_major = (rd_mode == MODE_ENC);

    assign wr_addr   = {wr_bank_q, wr_ofs};
    assign rd_addr   = {rd_bank_q, rd_ofs};
    assign out_valid = out_valid_q;
    assign blk_done  = blk_done_q;

    interleave_addr_gen #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_wr_gen (
        .clk         (clk),
        .rst         (rst),
        .adv_i       (wr_en),
        .col_major_i (wr_col_major),
        .ofs_o       (wr_ofs),
        .last_o      (wr_last)
    );

    interleave_addr_gen #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_rd_gen (
        .clk         (clk),
        .rst         (rst),
        .adv_i       (rd_en),
        .col_major_i (rd_col_major),
        .ofs_o       (rd_ofs),
        .last_o      (rd_last)
    );

    // Writes only target a non-full bank and reads only a full one, so the
    // two flag updates below always hit different banks and both survive
    // when a write block and a read block complete together.
    always_comb begin
        full_d      = full_q;
        bank_mode_d = bank_mode_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;

        if (wr_en && wr_first) begin
            bank_mode_d[wr_bank_q] = mode;
        end
        if (wr_en && wr_last) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        if (rd_en && rd_last) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end

        if (rd_en) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        blk_done_d = rd_en && rd_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q      <= '0;
            bank_mode_q <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            out_valid_q <= 1'b0;
            blk_done_q  <= 1'b0;
        end else begin
            full_q      <= full_d;
            bank_mode_q <= bank_mode_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            out_valid_q <= out_valid_d;
            blk_done_q  <= blk_done_d;
        end
    end

endmodule

// File: tb/tb_interleave_addr_ctrl.sv
// Bench for interleave_addr_ctrl with a 4x8 matrix. A block-level model
// (block counters, symbol queues and closed-form permutations) predicts
// every output each cycle; a small RAM inside the bench follows the DUT
// strobes so the delivered symbol order is checked end to end.
module tb_interleave_addr_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int N    = ROWS * COLS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic        out_valid;
    logic        blk_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    interleave_addr_ctrl #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .blk_done  (blk_done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Offset of the j-th write / k-th read of a block for a given block mode.
    function automatic int wofs(int j, bit m);
        return m ? (j % ROWS) * COLS + j / ROWS : j;
    endfunction
    function automatic int rofs(int k, bit m);
        return m ? k : (k % ROWS) * COLS + k / ROWS;
    endfunction

    // ---------------- reference model ----------------
    int wblk = 0, rblk = 0, wj = 0, rk = 0, sym = 0, rdata = 0;
    bit cur_wmode = 0, ov_m = 0, bd_m = 0;
    bit fmodes[$];
    int exp_out[$];
    int blk_syms[N];
    int mem[4096];

    always @(negedge clk) begin : model
        bit e_ir, e_wr, e_rd, m_eff;
        int ea;
        if (rst) begin
            wblk = 0; rblk = 0; wj = 0; rk = 0;
            ov_m = 0; bd_m = 0;
            fmodes.delete();
            exp_out.delete();
        end else begin
            e_ir = (wblk - rblk) < 2;
            e_wr = in_valid && e_ir;
            e_rd = ((wblk - rblk) >= 1) && (!ov_m || out_ready);
            chk("in_ready", in_ready, e_ir);
            chk("wr_en", wr_en, e_wr);
            if (e_wr) begin
                m_eff = (wj == 0) ? mode : cur_wmode;
                ea = ((wblk % 2) << 11) | wofs(wj, m_eff);
                chk("wr_addr", wr_addr, ea);
            end
            chk("rd_en", rd_en, e_rd);
            if (e_rd) begin
                ea = ((rblk % 2) << 11) | rofs(rk, fmodes[0]);
                chk("rd_addr", rd_addr, ea);
            end
            chk("out_valid", out_valid, ov_m);
            chk("blk_done", blk_done, bd_m);
            if (ov_m && out_ready) begin
                if (exp_out.size() == 0) chk("data_underflow", 1, 0);
                else chk("rd_data", rdata, exp_out.pop_front());
            end

            // bench RAM follows the DUT's own strobes
            if (rd_en) rdata = mem[rd_addr];
            if (wr_en) mem[wr_addr] = sym;

            bd_m = e_rd && (rk == N - 1);
            ov_m = e_rd ? 1'b1 : (out_ready ? 1'b0 : ov_m);
            if (e_rd) begin
                if (rk == N - 1) begin
                    rk = 0;
                    rblk++;
                    void'(fmodes.pop_front());
                end else begin
                    rk++;
                end
            end
            if (e_wr) begin
                if (wj == 0) cur_wmode = mode;
                blk_syms[wj] = sym;
                if (wj == N - 1) begin
                    for (int k = 0; k < N; k++)
                        exp_out.push_back(cur_wmode ? blk_syms[(k % COLS) * ROWS + k / COLS]
                                                    : blk_syms[(k % ROWS) * COLS + k / ROWS]);
                    fmodes.push_back(cur_wmode);
                    wblk++;
                    wj = 0;
                end else begin
                    wj++;
                end
            end
            sym++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_blk_done"}, blk_done, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
    endtask

    int enc_rd_tab [8] = '{0, 8, 16, 24, 1, 9, 17, 25};
    int dec_wr_tab [5] = '{12'h800, 12'h808, 12'h810, 12'h818, 12'h801};

    initial begin
        int nw, nr, nlow;
        bit found;

        // reset
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk_reset_state("rst0");

        // encode block: row-major writes, column-major reads
        mode = 1'b0;
        out_ready = 1'b1;
        step();
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            #1;
            chk("enc_wr_addr", wr_addr, i);
            step();
        end
        in_valid = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("enc_rd_en", rd_en, 1);
            chk("enc_rd_addr", rd_addr, enc_rd_tab[k]);
            step();
            #1;
        end
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            #1;
            if (blk_done) found = 1;
        end
        chk("enc_blk_done_seen", found, 1);
        chk("enc_blk_done_with_valid", out_valid, 1);

        // decode block into bank 1: column-major writes, row-major reads
        mode = 1'b1;
        step();
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            #1;
            if (i < 5) chk("dec_wr_addr", wr_addr, dec_wr_tab[i]);
            step();
        end
        in_valid = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("dec_rd_en", rd_en, 1);
            chk("dec_rd_addr", rd_addr, 12'h800 + k);
            step();
            #1;
        end
        repeat (40) step();

        // downstream stalled: both banks fill, one read only
        mode = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        nw = 0;
        nr = 0;
        for (int c = 0; c < 80; c++) begin
            #1;
            nw += int'(wr_en);
            nr += int'(rd_en);
            step();
        end
        #1;
        chk("stall_writes", nw, 64);
        chk("stall_reads", nr, 1);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (100) step();

        // mode change mid-block is deferred to the next block
        mode = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (i == 10) mode = 1'b1;
            #1;
            if (i == 10) chk("toggle_wr_addr", wr_addr, 10);
            step();
        end
        for (int i = 0; i < N; i++) begin
            #1;
            if (i == 1) chk("toggle_next_blk_addr", wr_addr, 12'h808);
            step();
        end
        in_valid = 1'b0;
        repeat (80) step();

        // streaming: write and read blocks complete in the same cycle
        mode = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        nw = 0;
        nlow = 0;
        for (int c = 0; c < 128; c++) begin
            #1;
            nlow += int'(!in_ready);
            nw += int'(wr_en);
            step();
        end
        chk("stream_in_ready_low", nlow, 0);
        chk("stream_writes", nw, 128);
        in_valid = 1'b0;
        repeat (80) step();

        // reset after 17 writes
        mode = 1'b0;
        in_valid = 1'b1;
        repeat (17) step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk_reset_state("rst17");
        in_valid = 1'b1;
        #1;
        chk("post_rst_wr_en", wr_en, 1);
        chk("post_rst_wr_addr", wr_addr, 0);
        step();
        in_valid = 1'b0;
        repeat (5) step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            mode      = 1'($urandom % 2);
            rst       = ($urandom % 700) == 0;
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (100) step();
        chk("drain_empty", exp_out.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
